mem_port_arbiter: RTL and testbench

Arbitrates the single-port unified instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. Grants one fixed-latency RAM transaction at a time and returns read data to the winner. Drives a pipeline stall while either requester waits. MEM has priority; a starvation guard guarantees IF forward progress.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/arb_lat_timer.sv | 33 +++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-RAM port arbiter and its latency timer.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;
    typedef enum logic {OWN_IF, OWN_MEM} arb_owner_e;

    localparam int unsigned STAT_W = 16;
    localparam int unsigned LAT_W  = 4;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM bus of mem_port_arbiter. The stat counter outputs
// exist only when ARB_STATS_EN is defined.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_gnt;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_rdata;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              pipe_stall;
`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_if_gnt;
    logic [STAT_W-1:0] stat_mem_gnt;
    logic [STAT_W-1:0] stat_conflict;
`endif

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        output if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata, pipe_stall
`ifdef ARB_STATS_EN
        , output stat_if_gnt, stat_mem_gnt, stat_conflict
`endif
    );

    // Pipeline and RAM side.
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
        input  if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata, pipe_stall
`ifdef ARB_STATS_EN
        , input stat_if_gnt, stat_mem_gnt, stat_conflict
`endif
    );

endinterface

// File: rtl/arb_lat_timer.sv
// Loadable down-counter; done is high while the count is 1, i.e. load_val
// cycles after the load edge.
module arb_lat_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between IF and MEM: MEM has priority, a starvation
// counter forces IF through. Optional stat counters behind ARB_STATS_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [LAT_W-1:0]  starve_q, starve_d;
    logic              arb_en, grant, pick_if, lat_done;

    arb_lat_timer #(.W(LAT_W)) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ISSUE),
        .load_val (LAT_W'(MEM_LAT)),
        .done     (lat_done)
    );

    always_comb begin
        arb_en      = (state_q == IDLE) || (state_q == DONE);
        grant       = arb_en && (bus.if_req || bus.mem_req);
        pick_if     = bus.if_req && (!bus.mem_req || (starve_q == LAT_W'(STARVE_MAX)));
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        starve_d    = starve_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        unique case (state_q)
            IDLE, DONE: state_d = grant ? ISSUE : IDLE;
            ISSUE:      state_d = WAIT;
            WAIT:       if (lat_done) state_d = DONE;
            default:    state_d = IDLE;
        endcase

        if (grant) begin
            if (pick_if) begin
                owner_d  = OWN_IF;
                addr_d   = bus.if_addr;
                we_d     = 1'b0;
                starve_d = '0;
            end else begin
                owner_d = OWN_MEM;
                addr_d  = bus.mem_addr;
                wdata_d = bus.mem_wdata;
                we_d    = bus.mem_we;
                if (!bus.if_req) begin
                    starve_d = '0;
                end else if (starve_q != LAT_W'(STARVE_MAX)) begin
                    starve_d = starve_q + LAT_W'(1);
                end
            end
        end

        // ram_rdata is valid in the last WAIT cycle; stores leave mem_rdata alone.
        if ((state_q == WAIT) && lat_done) begin
            if (owner_q == OWN_IF) begin
                if_rdata_d = bus.ram_rdata;
            end else if (!we_q) begin
                mem_rdata_d = bus.ram_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            starve_q    <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            starve_q    <= starve_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign bus.ram_en     = (state_q == ISSUE);
    assign bus.ram_we     = (state_q == ISSUE) && we_q;
    assign bus.ram_addr   = addr_q;
    assign bus.ram_wdata  = wdata_q;
    assign bus.if_gnt     = (state_q == ISSUE) && (owner_q == OWN_IF);
    assign bus.mem_gnt    = (state_q == ISSUE) && (owner_q == OWN_MEM);
    assign bus.if_valid   = (state_q == DONE) && (owner_q == OWN_IF);
    assign bus.mem_valid  = (state_q == DONE) && (owner_q == OWN_MEM);
    assign bus.if_rdata   = if_rdata_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.pipe_stall = (bus.if_req && !bus.if_valid) || (bus.mem_req && !bus.mem_valid);

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] stat_if_q, stat_mem_q, stat_conf_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_if_q   <= '0;
            stat_mem_q  <= '0;
            stat_conf_q <= '0;
        end else begin
            stat_if_q   <= sat_inc(stat_if_q, grant && pick_if);
            stat_mem_q  <= sat_inc(stat_mem_q, grant && !pick_if);
            stat_conf_q <= sat_inc(stat_conf_q, arb_en && bus.if_req && bus.mem_req);
        end
    end

    assign bus.stat_if_gnt   = stat_if_q;
    assign bus.stat_mem_gnt  = stat_mem_q;
    assign bus.stat_conflict = stat_conf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level timing model predicts every
// grant/valid pulse and read value; a negedge monitor compares the DUT against it.
module tb_mem_port_arbiter;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 2;
    localparam int unsigned SMAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MEM_LAT    (LAT),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          cyc;
        bit          is_if;
        bit          is_valid;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } ev_t;

    ev_t         exp_q[$];
    string       glog[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] ram[logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          n_cyc  = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h want %h", name, n_cyc, got, want);
        end
    endtask

    // Reference model: one transaction at a time, MEM first unless IF has been
    // passed over SMAX times in a row; gnt one cycle after the decision, valid
    // LAT+2 cycles after it, and the next decision allowed in the valid cycle.
    int m_cyc = -1;
    int free_at = 0;
    int starve = 0;
    always @(posedge clk) begin
        if (!rst) begin
            free_at = m_cyc + 1;
            starve  = 0;
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > m_cyc) void'(exp_q.pop_back());
        end else if (m_cyc >= free_at && (bus.if_req || bus.mem_req)) begin
            ev_t g;
            ev_t v;
            g.is_if    = bus.if_req && (!bus.mem_req || starve == SMAX);
            g.cyc      = m_cyc + 1;
            g.is_valid = 1'b0;
            g.we       = g.is_if ? 1'b0 : bus.mem_we;
            g.addr     = g.is_if ? bus.if_addr : bus.mem_addr;
            g.wdata    = bus.mem_wdata;
            g.rdata    = '0;
            if (!g.we) g.rdata = ref_mem.exists(g.addr) ? ref_mem[g.addr] : init_word(g.addr);
            else ref_mem[g.addr] = g.wdata;
            if (g.is_if) starve = 0;
            else if (bus.if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
            else starve = 0;
            v = g;
            v.cyc      = m_cyc + LAT + 2;
            v.is_valid = 1'b1;
            exp_q.push_back(g);
            exp_q.push_back(v);
            free_at = m_cyc + LAT + 2;
        end
        m_cyc++;
    end

    // RAM: data for a read is presented only in the cycle it is due.
    int          r_cyc = -1;
    int          rd_cyc = -100;
    logic [31:0] rd_val = '0;
    always @(posedge clk) begin
        if (bus.ram_en === 1'b1) begin
            if (bus.ram_we) begin
                ram[bus.ram_addr] = bus.ram_wdata;
            end else begin
                rd_cyc = r_cyc + LAT;
                rd_val = ram.exists(bus.ram_addr) ? ram[bus.ram_addr] : init_word(bus.ram_addr);
            end
        end
        r_cyc++;
        #1 bus.ram_rdata = (r_cyc == rd_cyc) ? rd_val : $urandom;
    end

    // Monitor
    logic [31:0] ref_if_rd = '0;
    logic [31:0] ref_mem_rd = '0;
    bit          prev_rst = 1'b0;
    always @(negedge clk) begin
        bit  e_ig, e_mg, e_iv, e_mv;
        ev_t gev;
        e_ig = 0; e_mg = 0; e_iv = 0; e_mv = 0;
        gev  = '{default: '0};
        if (!prev_rst) begin
            ref_if_rd  = '0;
            ref_mem_rd = '0;
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= n_cyc) begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc == n_cyc) begin
                if (!e.is_valid) begin
                    gev = e;
                    if (e.is_if) e_ig = 1; else e_mg = 1;
                end else if (e.is_if) begin
                    e_iv = 1;
                    ref_if_rd = e.rdata;
                end else begin
                    e_mv = 1;
                    if (!e.we) ref_mem_rd = e.rdata;
                end
            end
        end
        if (bus.if_gnt === 1'b1) glog.push_back("I");
        if (bus.mem_gnt === 1'b1) glog.push_back("M");
        check("if_gnt", bus.if_gnt, e_ig);
        check("mem_gnt", bus.mem_gnt, e_mg);
        check("ram_en", bus.ram_en, e_ig | e_mg);
        check("if_valid", bus.if_valid, e_iv);
        check("mem_valid", bus.mem_valid, e_mv);
        if (e_ig || e_mg) begin
            check("ram_addr", bus.ram_addr, gev.addr);
            check("ram_we", bus.ram_we, gev.we);
            if (gev.we) check("ram_wdata", bus.ram_wdata, gev.wdata);
        end
        check("if_rdata", bus.if_rdata, ref_if_rd);
        check("mem_rdata", bus.mem_rdata, ref_mem_rd);
        check("pipe_stall", bus.pipe_stall,
              (bus.if_req & ~e_iv) | (bus.mem_req & ~e_mv));
        prev_rst = rst;
        n_cyc++;
    end

    // Stimulus
    bit i_act = 0, i_gnt = 0, m_act = 0, m_gnt = 0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_hold(input int n, input bit keep_if, input bit keep_mem);
        for (int k = 0; k < n; k++) begin
            next_cycle();
            if (bus.if_valid && !keep_if) bus.if_req = 1'b0;
            if (bus.mem_valid && !keep_mem) bus.mem_req = 1'b0;
        end
    endtask

    task automatic wait_valid(input bit is_if, input int start, input string name,
                              input int want_lat);
        int lat;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            next_cycle();
            if (is_if ? bus.if_valid : bus.mem_valid) begin
                lat = n_cyc - start;
                break;
            end
        end
        check(name, lat, want_lat);
    endtask

    task automatic new_if();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'($urandom_range(0, 15)) << 2;
        i_act = 1;
        i_gnt = 0;
    endtask

    task automatic new_mem();
        bus.mem_req   = 1'b1;
        bus.mem_we    = ($urandom_range(0, 2) == 0);
        bus.mem_addr  = 32'($urandom_range(0, 15)) << 2;
        bus.mem_wdata = $urandom;
        m_act = 1;
        m_gnt = 0;
    endtask

    task automatic drive_if();
        if (i_gnt) begin
            if (bus.if_valid) begin
                i_gnt = 0;
                if ($urandom_range(0, 1) == 1) new_if();
                else begin bus.if_req = 1'b0; i_act = 0; end
            end
        end else if (i_act) begin
            if (bus.if_gnt) begin
                i_gnt = 1;
                if ($urandom_range(0, 3) == 0) bus.if_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.if_req = 1'b0;
                i_act = 0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            new_if();
        end
    endtask

    task automatic drive_mem();
        if (m_gnt) begin
            if (bus.mem_valid) begin
                m_gnt = 0;
                if ($urandom_range(0, 1) == 1) new_mem();
                else begin bus.mem_req = 1'b0; m_act = 0; end
            end
        end else if (m_act) begin
            if (bus.mem_gnt) begin
                m_gnt = 1;
                if ($urandom_range(0, 3) == 0) bus.mem_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.mem_req = 1'b0;
                m_act = 0;
            end
        end else if ($urandom_range(0, 1) == 0) begin
            new_mem();
        end
    endtask

    initial begin
        int    c0;
        string s;
        ram[32'h10]     = 32'hDEAD_BEEF;
        ref_mem[32'h10] = 32'hDEAD_BEEF;
        bus.ram_rdata = '0;
        bus.mem_wdata = '0;
        bus.mem_we    = 1'b0;
        // Reset held two cycles with both requests up, then MEM wins the conflict.
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h10;
        bus.mem_req  = 1'b1;
        bus.mem_addr = 32'h40;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        run_hold(25, 0, 0);

        // Lone fetch
        next_cycle();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        c0 = n_cyc;
        wait_valid(1, c0, "fetch_latency", LAT + 2);
        check("fetch_data", bus.if_rdata, 32'hDEAD_BEEF);
        bus.if_req = 1'b0;
        run_hold(3, 0, 0);

        // Store
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 32'h20;
        bus.mem_wdata = 32'h0000_005A;
        c0 = n_cyc;
        wait_valid(0, c0, "store_latency", LAT + 2);
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        run_hold(3, 0, 0);

        // Starvation: both permanently requesting
        glog.delete();
        bus.if_req  = 1'b1;
        bus.mem_req = 1'b1;
        run_hold(44, 1, 1);
        s = "";
        for (int k = 0; k < 8 && k < glog.size(); k++) s = {s, glog[k]};
        checks++;
        if (s != "MMMIMMMI") begin
            errors++;
            $display("FAIL grant_order: got %s want MMMIMMMI", s);
        end
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        run_hold(10, 0, 0);

        // Reset in the middle of a fetch, then a fresh fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        c0 = n_cyc;
        wait_valid(1, c0, "post_reset_latency", LAT + 2);
        bus.if_req = 1'b0;
        run_hold(3, 0, 0);

        // Random traffic with occasional reset pulses
        for (int k = 0; k < 3000; k++) begin
            next_cycle();
            if (!rst) begin
                rst   = 1'b1;
                i_gnt = 0;
                m_gnt = 0;
                i_act = bus.if_req;
                m_act = bus.mem_req;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0;
            end
            drive_if();
            drive_mem();
        end
        rst         = 1'b1;
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        run_hold(20, 0, 0);
        check("drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
